// File: rtl/rv32i_mem_pkg.sv
// Shared RV32I load/store definitions: MemOp (funct3) encodings, responder
// FSM states, and the byte-enable / store-align / load-extend helpers used by
// both the data bus responder and the core's load/store unit.
package rv32i_mem_pkg;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_RESP   = 2'd3
    } bus_state_e;

    // Unsigned variants only make sense for loads.
    function automatic logic memop_legal(input logic [2:0] op, input logic wr);
        case (op)
            MEMOP_B, MEMOP_H, MEMOP_W: memop_legal = 1'b1;
            MEMOP_BU, MEMOP_HU:        memop_legal = !wr;
            default:                   memop_legal = 1'b0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lane);
        case (op)
            MEMOP_H, MEMOP_HU: misaligned = lane[0];
            MEMOP_W:           misaligned = (lane != 2'b00);
            default:           misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_enable(input logic [2:0] op, input logic [1:0] lane);
        case (op)
            MEMOP_B: byte_enable = 4'b0001 << lane;
            MEMOP_H: byte_enable = lane[1] ? 4'b1100 : 4'b0011;
            MEMOP_W: byte_enable = 4'b1111;
            default: byte_enable = 4'b0000;
        endcase
    endfunction

    // Replicate right-aligned store data across lanes; byte enables pick the live ones.
    function automatic logic [31:0] store_align(input logic [2:0] op, input logic [31:0] data);
        case (op)
            MEMOP_B: store_align = {4{data[7:0]}};
            MEMOP_H: store_align = {2{data[15:0]}};
            default: store_align = data;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [1:0] lane,
                                                input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (op)
            MEMOP_B:  load_extend = {{24{sh[7]}}, sh[7:0]};
            MEMOP_BU: load_extend = {24'h0, sh[7:0]};
            MEMOP_H:  load_extend = {{16{sh[15]}}, sh[15:0]};
            MEMOP_HU: load_extend = {16'h0, sh[15:0]};
            MEMOP_W:  load_extend = word;
            default:  load_extend = 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// Single-port DEPTH_WORDS x 32 RAM with per-byte write enables.
// Latency: write lands on the clock edge; read data is registered (1 cycle), read-before-write.
// Ports: clk, we[3:0] byte enables, addr word index, wdata lane-aligned data, rdata registered word.
module mem_word_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_bus_responder.sv
// Memory-side load/store responder with RV32I B/H/W(/U) semantics and programmable wait states.
// Latency: RspValid is high WAIT_CYCLES+2 cycles after the accept cycle; one request outstanding.
// Backpressure: RspReady low holds RESP with stable outputs; ReqReady stays low until the handshake.
// Ports: Clk/Rst (sync, active high); request ReqValid/ReqReady/Addr/MemOp/WrEn/DataIn;
//        response RspValid/RspReady/DataOut/Err.
module data_bus_responder
    import rv32i_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [31:0] Addr,
    input  logic [2:0]  MemOp,
    input  logic        WrEn,
    input  logic [31:0] DataIn,
    output logic        RspValid,
    input  logic        RspReady,
    output logic [31:0] DataOut,
    output logic        Err
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

    bus_state_e  state;
    logic [3:0]  wait_cnt;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [2:0]  req_op;
    logic        req_wr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;

    logic [31:0]   req_off;
    logic [1:0]    lane;
    logic          req_bad;
    logic [AW-1:0] ram_addr;
    logic [3:0]    ram_we;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    assign req_off = req_addr - BASE_ADDR;
    assign lane    = req_addr[1:0];
    assign req_bad = (req_off >= SPAN) || !memop_legal(req_op, req_wr) || misaligned(req_op, lane);

    // The registered read must already hold the word during COMMIT, so the address is
    // driven one edge early: from the live request in IDLE, from the latched one in WAIT.
    // BASE_ADDR is aligned to the array span, so the word index is just the address bits.
    assign ram_addr  = (state == ST_IDLE) ? Addr[AW+1:2] : req_addr[AW+1:2];
    assign ram_we    = (state == ST_COMMIT && !Rst && req_wr && !req_bad)
                       ? byte_enable(req_op, lane) : 4'b0000;
    assign ram_wdata = store_align(req_op, req_data);

    mem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (AW)
    ) u_array (
        .clk   (Clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Request capture; only meaningful once accepted, so no reset needed.
    always_ff @(posedge Clk) begin
        if (!Rst && state == ST_IDLE && ReqValid) begin
            req_addr <= Addr;
            req_op   <= MemOp;
            req_wr   <= WrEn;
            req_data <= DataIn;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= ST_IDLE;
            wait_cnt  <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ReqValid) begin
                        if (WAIT_CYCLES > 0) begin
                            state    <= ST_WAIT;
                            wait_cnt <= 4'(WAIT_CYCLES - 1);
                        end else begin
                            state <= ST_COMMIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= ST_COMMIT;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_COMMIT: begin
                    rsp_data  <= (req_bad || req_wr) ? 32'h0 : load_extend(req_op, lane, ram_rdata);
                    rsp_err   <= req_bad;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (RspReady) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ReqReady = (state == ST_IDLE) && !Rst;
    assign RspValid = rsp_valid;
    assign DataOut  = rsp_data;
    assign Err      = rsp_err;

endmodule

// File: tb/tb_data_bus_responder.sv
// Bench for data_bus_responder: three instances (WAIT_CYCLES 1, 4, 0; the last at a
// non-zero base), directed cases plus random traffic against a byte-array reference model.
module tb_data_bus_responder;

    localparam int DEPTH = 64;
    localparam int BYTES = DEPTH * 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0]       rst, req_valid, wr_en, rsp_ready;
    logic [2:0][31:0] addr, data_in;
    logic [2:0][2:0]  mem_op;
    wire  [2:0]       req_ready, rsp_valid, err;
    wire  [2:0][31:0] data_out;

    data_bus_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(1)) u0 (
        .Clk(clk), .Rst(rst[0]), .ReqValid(req_valid[0]), .ReqReady(req_ready[0]),
        .Addr(addr[0]), .MemOp(mem_op[0]), .WrEn(wr_en[0]), .DataIn(data_in[0]),
        .RspValid(rsp_valid[0]), .RspReady(rsp_ready[0]), .DataOut(data_out[0]), .Err(err[0]));

    data_bus_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(4)) u1 (
        .Clk(clk), .Rst(rst[1]), .ReqValid(req_valid[1]), .ReqReady(req_ready[1]),
        .Addr(addr[1]), .MemOp(mem_op[1]), .WrEn(wr_en[1]), .DataIn(data_in[1]),
        .RspValid(rsp_valid[1]), .RspReady(rsp_ready[1]), .DataOut(data_out[1]), .Err(err[1]));

    data_bus_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h1000), .WAIT_CYCLES(0)) u2 (
        .Clk(clk), .Rst(rst[2]), .ReqValid(req_valid[2]), .ReqReady(req_ready[2]),
        .Addr(addr[2]), .MemOp(mem_op[2]), .WrEn(wr_en[2]), .DataIn(data_in[2]),
        .RspValid(rsp_valid[2]), .RspReady(rsp_ready[2]), .DataOut(data_out[2]), .Err(err[2]));

    int n_checks = 0;
    int n_pass   = 0;
    int last_acc [3];
    logic [7:0] mem_m [3][BYTES];

    function automatic int wait_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 4 : 0;
    endfunction

    function automatic logic [31:0] base_of(input int d);
        return (d == 2) ? 32'h1000 : 32'h0;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    // Reference: byte-addressed little-endian memory, access size from MemOp.
    function automatic void model(input int d, input logic [31:0] a, input logic [2:0] op,
                                  input logic wr, input logic [31:0] din,
                                  output logic [31:0] rd, output logic e);
        logic [31:0] off;
        int size;
        off = a - base_of(d);
        case (op)
            3'b000, 3'b100: size = 1;
            3'b001, 3'b101: size = 2;
            3'b010:         size = 4;
            default:        size = 0;
        endcase
        rd = 32'h0;
        if (size == 0) e = 1'b1;
        else e = (wr && op[2]) || (off >= 32'(BYTES)) || ((a & 32'(size - 1)) != 32'h0);
        if (e) return;
        if (wr) begin
            for (int i = 0; i < size; i++) mem_m[d][off + 32'(i)] = din[8*i +: 8];
        end else begin
            for (int i = size - 1; i >= 0; i--) rd = (rd << 8) | 32'(mem_m[d][off + 32'(i)]);
            if (!op[2] && size < 4 && rd[8*size-1]) rd = rd | ~((32'd1 << (8*size)) - 32'd1);
        end
    endfunction

    // One full transaction; hold>0 keeps RspReady low that many cycles while a
    // competing store is presented, which must be ignored.
    task automatic xact(input int d, input logic [31:0] a, input logic [2:0] op,
                        input logic wr, input logic [31:0] din, input int hold);
        logic [31:0] exp_d;
        logic        exp_e;
        int          n;
        n = 0;
        while (!req_ready[d] && n < 50) begin @(negedge clk); n++; end
        if (!req_ready[d]) begin check_val("req_ready_timeout", 32'(req_ready[d]), 32'd1); return; end
        model(d, a, op, wr, din, exp_d, exp_e);
        addr[d] = a; mem_op[d] = op; wr_en[d] = wr; data_in[d] = din; req_valid[d] = 1'b1;
        rsp_ready[d] = (hold == 0);
        last_acc[d] = cyc;
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        addr[d] = $urandom; data_in[d] = $urandom; mem_op[d] = 3'($urandom); wr_en[d] = 1'($urandom);
        n = 1;
        while (!rsp_valid[d] && n < 40) begin @(negedge clk); n++; end
        check_val("latency", 32'(n), 32'(wait_of(d) + 2));
        if (!rsp_valid[d]) return;
        check_val("data", data_out[d], exp_d);
        check_val("err", 32'(err[d]), 32'(exp_e));
        if (hold > 0) begin
            req_valid[d] = 1'b1; addr[d] = a & ~32'h3; mem_op[d] = 3'b010; wr_en[d] = 1'b1;
            data_in[d] = $urandom;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check_val("stall_valid", 32'(rsp_valid[d]), 32'd1);
                check_val("stall_data", data_out[d], exp_d);
                check_val("stall_err", 32'(err[d]), 32'(exp_e));
                check_val("stall_req_ready", 32'(req_ready[d]), 32'd0);
            end
            req_valid[d] = 1'b0;
            rsp_ready[d] = 1'b1;
        end
        @(negedge clk);
        check_val("rsp_drop", 32'(rsp_valid[d]), 32'd0);
        check_val("ready_back", 32'(req_ready[d]), 32'd1);
    endtask

    initial begin
        int prev;
        logic [31:0] a;
        rst = '1; req_valid = '0; wr_en = '0; rsp_ready = '1;
        addr = '0; data_in = '0; mem_op = '0;

        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check_val("rst_req_ready", 32'(req_ready[d]), 32'd0);
            check_val("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
            check_val("rst_data", data_out[d], 32'h0);
            check_val("rst_err", 32'(err[d]), 32'd0);
        end
        rst = '0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) check_val("post_rst_ready", 32'(req_ready[d]), 32'd1);

        for (int d = 0; d < 3; d++)
            for (int w = 0; w < DEPTH; w++)
                xact(d, base_of(d) + 32'(4 * w), 3'b010, 1'b1, $urandom, 0);

        // Directed byte/half/word semantics on the 1-wait instance.
        xact(0, 32'h10, 3'b010, 1'b1, 32'hDEADBEEF, 0);
        xact(0, 32'h10, 3'b010, 1'b0, 32'h0, 0);
        xact(0, 32'h11, 3'b000, 1'b1, 32'hFFFFFF7F, 0);
        xact(0, 32'h11, 3'b000, 1'b0, 32'h0, 0);
        xact(0, 32'h13, 3'b000, 1'b0, 32'h0, 0);
        xact(0, 32'h13, 3'b100, 1'b0, 32'h0, 0);
        xact(0, 32'h22, 3'b001, 1'b1, 32'h12348001, 0);
        xact(0, 32'h22, 3'b001, 1'b0, 32'h0, 0);
        xact(0, 32'h22, 3'b101, 1'b0, 32'h0, 0);
        xact(0, 32'h20, 3'b010, 1'b0, 32'h0, 0);
        xact(0, 32'h13, 3'b010, 1'b0, 32'h0, 0);
        xact(0, 32'h21, 3'b001, 1'b1, 32'hAAAA5555, 0);
        xact(0, 32'h20, 3'b010, 1'b0, 32'h0, 0);
        xact(0, 32'(BYTES), 3'b010, 1'b0, 32'h0, 0);
        xact(0, 32'h40, 3'b100, 1'b1, 32'h11111111, 0);
        xact(0, 32'h40, 3'b011, 1'b0, 32'h0, 0);
        xact(0, 32'h40, 3'b010, 1'b0, 32'h0, 0);
        xact(0, 32'h10, 3'b010, 1'b0, 32'h0, 5);
        xact(0, 32'h10, 3'b010, 1'b0, 32'h0, 0);

        // Reset two cycles into a 4-cycle wait: the store must never land.
        addr[1] = 32'h30; mem_op[1] = 3'b010; wr_en[1] = 1'b1; data_in[1] = 32'h12345678;
        req_valid[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        rst[1] = 1'b1;
        @(negedge clk);
        check_val("midwait_rst_ready", 32'(req_ready[1]), 32'd0);
        check_val("midwait_rst_valid", 32'(rsp_valid[1]), 32'd0);
        rst[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_val("midwait_no_rsp", 32'(rsp_valid[1]), 32'd0);
        end
        xact(1, 32'h30, 3'b010, 1'b0, 32'h0, 0);

        // Zero-wait instance with RspReady tied high: accepts every 3 cycles.
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            xact(2, 32'h1000 + 32'(4 * i), 3'b010, 1'b0, 32'h0, 0);
            if (i > 0) check_val("b2b_gap", 32'(last_acc[2] - prev), 32'd3);
            prev = last_acc[2];
        end

        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 120; i++) begin
                if ($urandom_range(0, 15) == 0) a = $urandom;
                else a = base_of(d) + 32'($urandom_range(0, BYTES + 7));
                xact(d, a, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom,
                     ($urandom_range(0, 7) == 0) ? 2 : 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_bus_responder.md
Name: data_bus_responder

Overview:
Memory-side responder for the core's load/store port. Accepts one load or store request per handshake and applies RV32I byte, half and word semantics selected by the funct3-coded MemOp. Inserts a programmable number of wait states and returns a registered response under a valid/ready handshake. Replaces the zero-latency data memory so the core and bus fabric can be exercised against a slave with real latency.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the backing array (power of 2)
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to DEPTH_WORDS*4
WAIT_CYCLES, 1, wait states between acceptance and commit (0..15)

Ports:
Clk  input  1  clock, rising edge
Rst  input  1  synchronous, active-high reset
ReqValid  input  1  request present
ReqReady  output  1  responder can accept a request
Addr  input  32  byte address
MemOp  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU; the U codes are legal for loads only
WrEn  input  1  1 = store, 0 = load
DataIn  input  32  store data, right-aligned
RspValid  output  1  response present
RspReady  input  1  requester accepts the response
DataOut  output  32  load data, sign- or zero-extended; 0 for stores and errors
Err  output  1  valid with RspValid; request was misaligned, out of range or used an illegal MemOp

Behaviour:
- Reset values: state IDLE, ReqReady=0 during the reset cycle then 1, RspValid=0, DataOut=0, Err=0, wait counter=0. Reset does not clear the backing array.
- States:
  - IDLE: ReqReady=1. If ReqValid=1, latch Addr, MemOp, WrEn and DataIn. Go to WAIT if WAIT_CYCLES>0, otherwise to COMMIT.
  - WAIT: ReqReady=0. The counter loads WAIT_CYCLES-1 on entry and decrements each cycle. Exit to COMMIT in the cycle it reads 0.
  - COMMIT: one cycle. Check the request and perform the access. Register DataOut and Err. Go to RESP.
  - RESP: RspValid=1, with DataOut and Err held stable. When RspReady=1, go to IDLE.
- Latency: RspValid rises WAIT_CYCLES+2 cycles after the accepting edge. The earliest next acceptance is the cycle after the RspValid&&RspReady handshake, so at most one request is outstanding.
- Offset = Addr - BASE_ADDR. A request is out of range when Offset >= DEPTH_WORDS*4.
- Misalignment: H/HU with Addr[0]=1, or W with Addr[1:0]!=0.
- Illegal MemOp: 011, 110, 111, or 100/101 with WrEn=1.
- Any error: no array write, DataOut=0, Err=1.
- Stores update only the addressed bytes, using byte enables from MemOp and Addr[1:0]:
  - B writes DataIn[7:0] into lane Addr[1:0].
  - H writes DataIn[15:0] into lanes {Addr[1],0} and {Addr[1],1}.
  - W writes all four lanes.
  - A store returns DataOut=0, Err=0.
- Loads select the lane by Addr[1:0]. B and H sign-extend; BU and HU zero-extend; W returns the full word.
- Store then load to the same address returns the new data; the write lands in COMMIT, before any later request.
- Request inputs are ignored outside IDLE. Changes to Addr and DataIn after acceptance have no effect.
- RspReady held at 0 stalls in RESP indefinitely, with outputs stable.
- Rst asserted in any state returns the block to IDLE on that edge and drops the outstanding response. A store that has not reached COMMIT is not written; a store whose COMMIT has passed stays written.

Decomposition:
- Shared package rv32i_mem_pkg holds:
  - the MemOp encodings (MEMOP_B, MEMOP_H, MEMOP_W, MEMOP_BU, MEMOP_HU);
  - the FSM state encoding;
  - the byte-enable and load-extend functions, so the core's load/store unit uses the same definitions.
- One sub-module, mem_word_array: a DEPTH_WORDS x 32 synchronous-write RAM with 4 byte-write enables and a registered read. Read and write share a single port, so it maps to block RAM.

Test Plan:
- WAIT_CYCLES=1. Store W 0xDEADBEEF to 0x10, then load W from 0x10: RspValid rises 3 cycles after each accept, DataOut=0xDEADBEEF, Err=0.
- After that word is stored, store B 0x7F to 0x11, then issue LB 0x11, LB 0x13 and LBU 0x13. Expected DataOut: 0x0000007F, 0xFFFFFFDE, 0x000000DE.
- Store H 0x8001 to 0x22, then LH 0x22 returns 0xFFFF8001 and LHU 0x22 returns 0x00008001. The word at 0x20 changes in its upper half only.
- Misaligned accesses: LW 0x13 and SH 0x21 each give Err=1, DataOut=0. A follow-up LW 0x20 shows memory unchanged. Out of range: LW at DEPTH_WORDS*4 gives Err=1.
- Backpressure: hold RspReady=0 for 5 cycles. RspValid, DataOut and Err stay stable, ReqReady stays 0 and a new ReqValid is ignored. Release RspReady: back to IDLE, and the next request is accepted the following cycle.
- Reset mid-WAIT: use WAIT_CYCLES=4, store W 0x12345678 to 0x30, and assert Rst 2 cycles after accept. No RspValid appears, and a later LW 0x30 returns the old contents. With WAIT_CYCLES=0, back-to-back accepts occur every 3 cycles when RspReady is tied to 1.
